// File: rtl/flash_sample_fetch.sv
// rtl/flash_sample_fetch.sv - single-word Avalon-MM flash reader feeding the audio playback stage
//
// Walks a word address forward or backward through the song region
// [START_ADDR, END_ADDR]. Each word is read from the flash controller,
// registered into readdata and announced with a one-cycle finish pulse.
// The next read waits until the consumer pulses next_word.
//
// Build option: FLASH_FETCH_LOOP_EN
//   defined   - playback wraps endlessly at both region bounds
//   undefined - stepping past a bound parks in STOPPED until a restart pulse
//
// Ports:
//   CLK_50M                  in   system clock
//   reset                    in   asynchronous, active-low reset
//   play_en                  in   fetching allowed (sampled in IDLE)
//   direction                in   0 = forward, 1 = backward (sampled in ADVANCE)
//   restart                  in   pulse: jump to region start (fwd) / end (bwd)
//   next_word                in   pulse: current word consumed
//   flash_mem_waitrequest    in   Avalon stall
//   flash_mem_readdatavalid  in   Avalon read data valid
//   flash_mem_readdata       in   Avalon read data [31:0]
//   flash_mem_read           out  Avalon read request
//   flash_mem_address        out  Avalon word address [ADDR_W-1:0]
//   flash_mem_byteenable     out  constant 4'b1111
//   readdata                 out  registered sample word [31:0]
//   finish                   out  one-cycle pulse, readdata updated
//   address                  out  current word address [ADDR_W-1:0]

module flash_sample_fetch #(
    parameter int                ADDR_W     = 23,
    parameter logic [ADDR_W-1:0] START_ADDR = 23'h000000,
    parameter logic [ADDR_W-1:0] END_ADDR   = 23'h07FFFF
) (
    input  logic              CLK_50M,
    input  logic              reset,
    input  logic              play_en,
    input  logic              direction,
    input  logic              restart,
    input  logic              next_word,
    input  logic              flash_mem_waitrequest,
    input  logic              flash_mem_readdatavalid,
    input  logic [31:0]       flash_mem_readdata,
    output logic              flash_mem_read,
    output logic [ADDR_W-1:0] flash_mem_address,
    output logic [3:0]        flash_mem_byteenable,
    output logic [31:0]       readdata,
    output logic              finish,
    output logic [ADDR_W-1:0] address
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT_VALID,
        S_CAPTURE,
        S_WAIT_CONSUMER,
        S_ADVANCE,
        S_STOPPED
    } state_t;

    state_t              r_state;
    state_t              w_next_state;
    logic [ADDR_W-1:0]   r_address;
    logic [31:0]         r_hold;
    logic [31:0]         r_readdata;
    logic                r_finish;
    logic                r_restart_pending;

    logic                w_restart_any;
    logic                w_at_bound;
    logic                w_step_ok;
    logic                w_apply_jump;
    logic [ADDR_W-1:0]   w_jump_addr;
    logic [ADDR_W-1:0]   w_step_addr;

    // A restart arriving in the same cycle it can be applied counts as pending.
    assign w_restart_any = restart | r_restart_pending;

    // The bound being left depends on direction; the wrap target of that bound
    // is the same address a restart in that direction jumps to.
    assign w_at_bound  = direction ? (r_address == START_ADDR) : (r_address == END_ADDR);
    assign w_jump_addr = direction ? END_ADDR : START_ADDR;
    assign w_step_addr = w_at_bound ? w_jump_addr
                       : (direction ? r_address - 1'b1 : r_address + 1'b1);

`ifdef FLASH_FETCH_LOOP_EN
    assign w_step_ok = 1'b1;
`else
    assign w_step_ok = !w_at_bound;
`endif

    assign w_apply_jump = w_restart_any &&
                          (((r_state == S_IDLE) && !play_en) ||
                           (r_state == S_ADVANCE) ||
                           (r_state == S_STOPPED));

    // State register
    always_ff @(posedge CLK_50M or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:          if (play_en) w_next_state = S_ISSUE;
            S_ISSUE:         if (!flash_mem_waitrequest) w_next_state = S_WAIT_VALID;
            S_WAIT_VALID:    if (flash_mem_readdatavalid) w_next_state = S_CAPTURE;
            S_CAPTURE:       w_next_state = S_WAIT_CONSUMER;
            S_WAIT_CONSUMER: if (next_word) w_next_state = S_ADVANCE;
            S_ADVANCE:       w_next_state = (w_restart_any || w_step_ok) ? S_IDLE : S_STOPPED;
            S_STOPPED:       if (w_restart_any) w_next_state = S_IDLE;
            default:         w_next_state = S_IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        flash_mem_read = 1'b0;
        if (r_state == S_ISSUE) begin
            flash_mem_read = 1'b1;
        end
    end

    // Datapath. finish is registered alongside readdata so the pulse and the
    // new word appear on the same cycle at the consumer.
    always_ff @(posedge CLK_50M or negedge reset) begin
        if (!reset) begin
            r_address         <= START_ADDR;
            r_hold            <= '0;
            r_readdata        <= '0;
            r_finish          <= 1'b0;
            r_restart_pending <= 1'b0;
        end else begin
            r_finish <= (r_state == S_CAPTURE);
            if ((r_state == S_WAIT_VALID) && flash_mem_readdatavalid) begin
                r_hold <= flash_mem_readdata;
            end
            if (r_state == S_CAPTURE) begin
                r_readdata <= r_hold;
            end
            if (w_apply_jump) begin
                r_address         <= w_jump_addr;
                r_restart_pending <= 1'b0;
            end else begin
                r_restart_pending <= r_restart_pending | restart;
                if ((r_state == S_ADVANCE) && w_step_ok) begin
                    r_address <= w_step_addr;
                end
            end
        end
    end

    assign flash_mem_address    = r_address;
    assign flash_mem_byteenable = 4'b1111;
    assign readdata             = r_readdata;
    assign finish               = r_finish;
    assign address              = r_address;

endmodule

// File: tb/tb_flash_sample_fetch.sv
// tb/tb_flash_sample_fetch.sv - scoreboard bench for flash_sample_fetch

module tb_flash_sample_fetch;

    localparam logic [22:0] START_A = 23'h000000;
    localparam logic [22:0] END_A   = 23'h07FFFF;

    logic        CLK_50M   = 1'b0;
    logic        reset     = 1'b0;
    logic        play_en   = 1'b0;
    logic        direction = 1'b0;
    logic        restart   = 1'b0;
    logic        next_word = 1'b0;
    logic        wr        = 1'b1;
    logic        rdv       = 1'b0;
    logic [31:0] rdata     = 32'h0;

    logic        flash_mem_read;
    logic [22:0] flash_mem_address;
    logic [3:0]  flash_mem_byteenable;
    logic [31:0] readdata;
    logic        finish;
    logic [22:0] address;

    flash_sample_fetch dut (
        .CLK_50M                 (CLK_50M),
        .reset                   (reset),
        .play_en                 (play_en),
        .direction               (direction),
        .restart                 (restart),
        .next_word               (next_word),
        .flash_mem_waitrequest   (wr),
        .flash_mem_readdatavalid (rdv),
        .flash_mem_readdata      (rdata),
        .flash_mem_read          (flash_mem_read),
        .flash_mem_address       (flash_mem_address),
        .flash_mem_byteenable    (flash_mem_byteenable),
        .readdata                (readdata),
        .finish                  (finish),
        .address                 (address)
    );

    always #10 CLK_50M = ~CLK_50M;

    typedef struct packed {
        logic [31:0] data;
        logic [22:0] addr;
    } exp_t;

    exp_t sb_q[$];
    int   checks    = 0;
    int   errors    = 0;
    int   fin_count = 0;
    int   accepts   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Accepted Avalon reads
    always @(posedge CLK_50M) begin
        if (reset && flash_mem_read && !wr) accepts++;
    end

    // Scoreboard monitor
    exp_t mon_e;
    always @(negedge CLK_50M) begin
        if (finish) begin
            fin_count++;
            if (sb_q.size() == 0) begin
                chk("unexpected_finish", 32'(finish), 32'd0);
            end else begin
                mon_e = sb_q.pop_front();
                chk("finish_readdata", readdata, mon_e.data);
                chk("finish_address", 32'(address), 32'(mon_e.addr));
            end
        end
    end

    task automatic do_word(input logic [31:0] d, input int stall, input logic [22:0] ea, input bit rst_wv);
        int n;
        int acc0;
        int f0;
        bit ok;
        acc0 = accepts;
        wr   = 1'b1;
        n    = 0;
        while (!flash_mem_read && n < 20) begin
            @(negedge CLK_50M);
            n++;
        end
        chk("read_asserted", 32'(flash_mem_read), 32'd1);
        chk("read_address", 32'(flash_mem_address), 32'(ea));
        ok = 1'b1;
        for (int i = 0; i < stall; i++) begin
            @(negedge CLK_50M);
            if (!flash_mem_read || flash_mem_address !== ea) ok = 1'b0;
        end
        if (stall > 0) chk("stall_stable", 32'(ok), 32'd1);
        wr = 1'b0;
        @(negedge CLK_50M);
        wr = 1'b1;
        chk("read_dropped", 32'(flash_mem_read), 32'd0);
        chk("one_accept", 32'(accepts - acc0), 32'd1);
        if (rst_wv) begin
            restart   = 1'b1;
            direction = 1'b1;
            @(negedge CLK_50M);
            restart = 1'b0;
        end
        f0 = fin_count;
        sb_q.push_back('{data: d, addr: ea});
        rdv   = 1'b1;
        rdata = d;
        @(negedge CLK_50M);
        rdv   = 1'b0;
        rdata = 32'h0;
        n = 0;
        while (fin_count == f0 && n < 10) begin
            @(negedge CLK_50M);
            n++;
        end
        chk("finish_seen", 32'(fin_count - f0), 32'd1);
    endtask

    task automatic consume(input int delay, input bit with_rst, input logic [22:0] exp_addr, input string name);
        repeat (delay) @(negedge CLK_50M);
        next_word = 1'b1;
        restart   = with_rst;
        @(negedge CLK_50M);
        next_word = 1'b0;
        restart   = 1'b0;
        @(negedge CLK_50M);
        chk(name, 32'(address), 32'(exp_addr));
    endtask

    task automatic pulse_restart(input logic dir, input logic [22:0] exp_addr, input string name);
        direction = dir;
        restart   = 1'b1;
        @(negedge CLK_50M);
        restart = 1'b0;
        chk(name, 32'(address), 32'(exp_addr));
    endtask

    task automatic expect_idle(input int cycles, input string name);
        bit ok;
        ok = 1'b1;
        repeat (cycles) begin
            @(negedge CLK_50M);
            if (flash_mem_read) ok = 1'b0;
        end
        chk(name, 32'(ok), 32'd1);
    endtask

    initial begin
        bit ok;
        // Reset state
        repeat (3) @(negedge CLK_50M);
        chk("rst_read", 32'(flash_mem_read), 32'd0);
        chk("rst_finish", 32'(finish), 32'd0);
        chk("rst_readdata", readdata, 32'd0);
        chk("rst_address", 32'(address), 32'(START_A));
        chk("byteenable", 32'(flash_mem_byteenable), 32'hF);
        reset = 1'b1;
        @(negedge CLK_50M);

        // Forward fetch, no wait, slow consumer
        play_en   = 1'b1;
        direction = 1'b0;
        do_word(32'hA1B2C3D4, 0, 23'h0, 1'b0);
        chk("hold_readdata", readdata, 32'hA1B2C3D4);
        consume(3, 1'b0, 23'h1, "fwd_step");

        // Waitrequest stall of 5 cycles
        do_word(32'h11223344, 5, 23'h1, 1'b0);
        consume(0, 1'b0, 23'h2, "stall_step");

        // Backpressure: no next_word for 200 cycles
        do_word(32'hDEADBEEF, 0, 23'h2, 1'b0);
        ok = 1'b1;
        repeat (200) begin
            @(negedge CLK_50M);
            if (flash_mem_read || readdata !== 32'hDEADBEEF) ok = 1'b0;
        end
        chk("backpressure", 32'(ok), 32'd1);
        consume(0, 1'b0, 23'h3, "bp_step");

        // Restart during WAIT_VALID, backward
        do_word(32'h55AA55AA, 0, 23'h3, 1'b1);
        consume(0, 1'b0, END_A, "restart_wv_jump");

        // Backward step from region end
        do_word(32'h01020304, 0, END_A, 1'b0);
        consume(0, 1'b0, 23'h07FFFE, "bwd_step");

        // Restart and next_word together, forward jump wins over the step
        direction = 1'b0;
        do_word(32'hCAFEF00D, 0, 23'h07FFFE, 1'b0);
        consume(0, 1'b1, START_A, "restart_nw_jump");

        // Backward at region start
        direction = 1'b1;
        do_word(32'h0BADC0DE, 0, START_A, 1'b0);
`ifdef FLASH_FETCH_LOOP_EN
        consume(0, 1'b0, END_A, "bwd_wrap");
`else
        consume(0, 1'b0, START_A, "bwd_stop_addr");
        expect_idle(20, "stopped_no_read");
        pulse_restart(1'b1, END_A, "stopped_restart_end");
`endif

        // Forward at region end, play_en dropped mid-fetch
        direction = 1'b0;
        do_word(32'h76543210, 0, END_A, 1'b0);
        play_en = 1'b0;
`ifdef FLASH_FETCH_LOOP_EN
        consume(0, 1'b0, START_A, "fwd_wrap");
`else
        consume(0, 1'b0, END_A, "fwd_stop_addr");
        expect_idle(5, "stopped_no_read2");
        pulse_restart(1'b0, START_A, "stopped_restart_start");
`endif
        expect_idle(10, "play_off_no_read");

        // Restart in IDLE with play_en low applies at once
        pulse_restart(1'b1, END_A, "idle_restart_end");
        pulse_restart(1'b0, START_A, "idle_restart_start");

        // Reset mid-read, then a late readdatavalid
        play_en = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge CLK_50M);
            ok = flash_mem_read;
        end
        chk("rmr_read", 32'(ok), 32'd1);
        wr = 1'b0;
        @(negedge CLK_50M);
        wr      = 1'b1;
        play_en = 1'b0;
        reset   = 1'b0;
        @(negedge CLK_50M);
        reset = 1'b1;
        @(negedge CLK_50M);
        rdv   = 1'b1;
        rdata = 32'h99999999;
        @(negedge CLK_50M);
        rdv   = 1'b0;
        rdata = 32'h0;
        ok = 1'b1;
        repeat (5) begin
            @(negedge CLK_50M);
            if (finish || flash_mem_read || address !== START_A || readdata !== 32'h0) ok = 1'b0;
        end
        chk("reset_mid_read", 32'(ok), 32'd1);
        chk("sb_empty", 32'(sb_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
